// File: rtl/x2050_mdata_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x2050_mdata_pkg
// Purpose  : Shared opcode constants and store-FSM state encoding for the
//            multi-channel M data register bank.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package x2050_mdata_pkg;

    localparam logic [2:0] OP_HOLD    = 3'd0;
    localparam logic [2:0] OP_LOAD_T  = 3'd1;
    localparam logic [2:0] OP_HALF    = 3'd2;
    localparam logic [2:0] OP_BYTE_W  = 3'd3;
    localparam logic [2:0] OP_SHIFT_B = 3'd4;
    localparam logic [2:0] OP_CLEAR   = 3'd5;
    localparam logic [2:0] OP_STORE   = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } st_state_t;

endpackage
`default_nettype wire

// File: rtl/x2050_mdata_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : x2050_mdata_bank_if
// Purpose  : Control/data bundle of the M data register bank.
// Ports    : master drives i_* (ROS control, sources, storage ack) and
//            observes o_* (selected register, pointer, store request,
//            overrun pulse); slave is the bank side.
// Revision : 1.0  initial release
// ============================================================================
interface x2050_mdata_bank_if #(
    parameter int NBYTES = 4,
    parameter int NCH    = 2
);
    localparam int CHW = (NCH    > 1) ? $clog2(NCH)    : 1;
    localparam int PW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic                  i_ros_advance;
    logic [CHW-1:0]        i_ch;
    logic [2:0]            i_op;
    logic [8*NBYTES-1:0]   i_t_reg;
    logic [7:0]            i_w_reg;
    logic                  i_mb_load;
    logic [PW-1:0]         i_mb_val;
    logic                  i_mb_inc;
    logic                  i_force_last;
    logic                  i_st_ack;
    logic [8*NBYTES-1:0]   o_m_reg;
    logic [PW-1:0]         o_mb;
    logic                  o_st_req;
    logic [8*NBYTES-1:0]   o_st_data;
    logic [CHW-1:0]        o_st_ch;
    logic                  o_overrun;

    modport master (
        output i_ros_advance, i_ch, i_op, i_t_reg, i_w_reg, i_mb_load,
               i_mb_val, i_mb_inc, i_force_last, i_st_ack,
        input  o_m_reg, o_mb, o_st_req, o_st_data, o_st_ch, o_overrun
    );

    modport slave (
        input  i_ros_advance, i_ch, i_op, i_t_reg, i_w_reg, i_mb_load,
               i_mb_val, i_mb_inc, i_force_last, i_st_ack,
        output o_m_reg, o_mb, o_st_req, o_st_data, o_st_ch, o_overrun
    );
endinterface
`default_nettype wire

// File: rtl/x2050_mdata_chan.sv
`default_nettype none
// ============================================================================
// Module   : x2050_mdata_chan
// Purpose  : One channel copy of the M register and its byte pointer.
// Ports    : i_clk, i_reset    clock, synchronous active-high reset
//            sel               this channel is selected on an advancing cycle
//            op, t_reg, w_reg  operation and sources
//            mb_load/mb_val/mb_inc  pointer control
//            force_last        op uses last byte instead of stored pointer
//            m_reg, mb         register and pointer state
// Revision : 1.0  initial release
// ============================================================================
module x2050_mdata_chan
    import x2050_mdata_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int PW     = 2
) (
    input  wire logic                i_clk,
    input  wire logic                i_reset,
    input  wire logic                sel,
    input  wire logic [2:0]          op,
    input  wire logic [8*NBYTES-1:0] t_reg,
    input  wire logic [7:0]          w_reg,
    input  wire logic                mb_load,
    input  wire logic [PW-1:0]       mb_val,
    input  wire logic                mb_inc,
    input  wire logic                force_last,
    output logic      [8*NBYTES-1:0] m_reg,
    output logic      [PW-1:0]       mb
);
    localparam int            W    = 8 * NBYTES;
    localparam int            HW   = 4 * NBYTES;
    localparam logic [PW-1:0] LAST = PW'(NBYTES - 1);

    logic [W-1:0]  m_next;
    logic [PW-1:0] mb_next;
    logic [PW-1:0] eff_ptr;

    assign eff_ptr = force_last ? LAST : mb;

    always_comb begin
        m_next = m_reg;
        case (op)
            OP_LOAD_T:  m_next = t_reg;
            OP_HALF:    m_next = {m_reg[W-1 -: HW], t_reg[W-1 -: HW]};
            OP_BYTE_W: begin
                // Byte 0 is the most significant byte.
                for (int b = 0; b < NBYTES; b++) begin
                    if (eff_ptr == PW'(b))
                        m_next[8*(NBYTES-1-b) +: 8] = w_reg;
                end
            end
            OP_SHIFT_B: m_next = {m_reg[W-9:0], w_reg};
            OP_CLEAR:   m_next = '0;
            default:    m_next = m_reg;
        endcase
    end

    // Explicit wrap so non-power-of-two widths stay in range.
    always_comb begin
        mb_next = mb;
        if (mb_load)
            mb_next = mb_val;
        else if (mb_inc)
            mb_next = (mb == LAST) ? '0 : mb + PW'(1);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            m_reg <= '0;
            mb    <= '0;
        end else if (sel) begin
            m_reg <= m_next;
            mb    <= mb_next;
        end
    end
endmodule
`default_nettype wire

// File: rtl/x2050_mdata_bank.sv
`default_nettype none
// ============================================================================
// Module   : x2050_mdata_bank
// Purpose  : Multi-channel M data register bank with single-entry storage
//            write path and overrun detection.
// Ports    : i_clk, i_reset  clock, synchronous active-high reset
//            bus (slave)     ROS control, sources, pointer control, storage
//                            handshake and selected-channel outputs
// Revision : 1.0  initial release
// ============================================================================
module x2050_mdata_bank
    import x2050_mdata_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int NCH    = 2
) (
    input wire logic         i_clk,
    input wire logic         i_reset,
    x2050_mdata_bank_if.slave bus
);
    localparam int W   = 8 * NBYTES;
    localparam int CHW = (NCH    > 1) ? $clog2(NCH)    : 1;
    localparam int PW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    logic [W-1:0]  m_arr  [NCH];
    logic [PW-1:0] mb_arr [NCH];
    logic [W-1:0]  m_sel;
    logic [PW-1:0] mb_sel;

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            x2050_mdata_chan #(.NBYTES(NBYTES), .PW(PW)) u_chan (
                .i_clk      (i_clk),
                .i_reset    (i_reset),
                .sel        (bus.i_ros_advance && (bus.i_ch == CHW'(c))),
                .op         (bus.i_op),
                .t_reg      (bus.i_t_reg),
                .w_reg      (bus.i_w_reg),
                .mb_load    (bus.i_mb_load),
                .mb_val     (bus.i_mb_val),
                .mb_inc     (bus.i_mb_inc),
                .force_last (bus.i_force_last),
                .m_reg      (m_arr[c]),
                .mb         (mb_arr[c])
            );
        end
    endgenerate

    always_comb begin
        m_sel  = '0;
        mb_sel = '0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.i_ch == CHW'(c)) begin
                m_sel  = m_arr[c];
                mb_sel = mb_arr[c];
            end
        end
    end

    // Store FSM: single pending write, no queueing.
    st_state_t      state, state_next;
    logic [W-1:0]   st_data, st_data_next;
    logic [CHW-1:0] st_ch, st_ch_next;
    logic           overrun, overrun_next;
    logic           store_go;

    assign store_go = bus.i_ros_advance && (bus.i_op == OP_STORE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            st_data <= '0;
            st_ch   <= '0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            st_data <= st_data_next;
            st_ch   <= st_ch_next;
            overrun <= overrun_next;
        end
    end

    always_comb begin
        state_next   = state;
        st_data_next = st_data;
        st_ch_next   = st_ch;
        overrun_next = 1'b0;
        case (state)
            ST_IDLE: begin
                // Snapshot is the pre-op register value of the channel.
                if (store_go) begin
                    state_next   = ST_REQ;
                    st_data_next = m_sel;
                    st_ch_next   = bus.i_ch;
                end
            end
            ST_REQ: begin
                if (bus.i_st_ack)
                    state_next = ST_IDLE;
                // A STORE in the ack cycle is still rejected.
                if (store_go)
                    overrun_next = 1'b1;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.o_m_reg   = m_sel;
    assign bus.o_mb      = mb_sel;
    assign bus.o_st_req  = (state == ST_REQ);
    assign bus.o_st_data = st_data;
    assign bus.o_st_ch   = st_ch;
    assign bus.o_overrun = overrun;
endmodule
`default_nettype wire

// File: tb/tb_x2050_mdata_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_x2050_mdata_bank
// Purpose  : Directed self-checking bench for x2050_mdata_bank (NBYTES=4,
//            NCH=2).
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_x2050_mdata_bank;
    import x2050_mdata_pkg::*;

    logic clk;
    logic rst;
    int   passed;
    int   total;

    x2050_mdata_bank_if #(.NBYTES(4), .NCH(2)) bus ();

    x2050_mdata_bank #(.NBYTES(4), .NCH(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Drive one cycle of inputs, clock it, then sample 1 ns later.
    task automatic cyc(input logic adv, input logic ch, input logic [2:0] op,
                       input logic [31:0] t, input logic [7:0] w,
                       input logic ld, input logic [1:0] val,
                       input logic inc, input logic frc, input logic ack);
        bus.i_ros_advance = adv;
        bus.i_ch          = ch;
        bus.i_op          = op;
        bus.i_t_reg       = t;
        bus.i_w_reg       = w;
        bus.i_mb_load     = ld;
        bus.i_mb_val      = val;
        bus.i_mb_inc      = inc;
        bus.i_force_last  = frc;
        bus.i_st_ack      = ack;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst    = 1'b1;
        cyc(0, 0, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        check("rst_m", bus.o_m_reg, 0);
        check("rst_mb", bus.o_mb, 0);
        check("rst_req", bus.o_st_req, 0);
        check("rst_data", bus.o_st_data, 0);
        check("rst_ovr", bus.o_overrun, 0);
        rst = 1'b0;

        // LOAD_T with pointer load 2, then BYTE_W at byte 2
        cyc(1, 0, OP_LOAD_T, 32'h11223344, 0, 1, 2, 0, 0, 0);
        check("load_t", bus.o_m_reg, 32'h11223344);
        check("mb_load", bus.o_mb, 2);
        cyc(1, 0, OP_BYTE_W, 0, 8'hAA, 0, 0, 0, 0, 0);
        check("byte_w_p2", bus.o_m_reg, 32'h1122AA44);

        // Pointer 3, four BYTE_W with post-increment and wrap
        cyc(1, 0, OP_CLEAR, 0, 0, 1, 3, 0, 0, 0);
        check("clear", bus.o_m_reg, 0);
        cyc(1, 0, OP_BYTE_W, 0, 8'h01, 0, 0, 1, 0, 0);
        check("bw1", bus.o_m_reg, 32'h00000001);
        check("wrap_mb", bus.o_mb, 0);
        cyc(1, 0, OP_BYTE_W, 0, 8'h02, 0, 0, 1, 0, 0);
        cyc(1, 0, OP_BYTE_W, 0, 8'h03, 0, 0, 1, 0, 0);
        cyc(1, 0, OP_BYTE_W, 0, 8'h04, 0, 0, 1, 0, 0);
        check("bw4", bus.o_m_reg, 32'h02030401);
        check("bw4_mb", bus.o_mb, 3);

        // force_last with stored pointer 1: writes byte 3, pointer untouched
        cyc(1, 0, OP_HOLD, 0, 0, 1, 1, 0, 0, 0);
        cyc(1, 0, OP_BYTE_W, 0, 8'hEE, 0, 0, 0, 1, 0);
        check("force_last", bus.o_m_reg, 32'h020304EE);
        check("force_mb", bus.o_mb, 1);

        // HALF and SHIFT_B
        cyc(1, 0, OP_LOAD_T, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, OP_HALF, 32'h12345678, 0, 0, 0, 0, 0, 0);
        check("half", bus.o_m_reg, 32'hDEAD1234);
        cyc(1, 0, OP_SHIFT_B, 0, 8'h55, 0, 0, 0, 0, 0);
        check("shift_b", bus.o_m_reg, 32'hAD123455);
        cyc(1, 0, 3'd7, 32'hFFFFFFFF, 8'hFF, 0, 0, 0, 0, 0);
        check("op7_hold", bus.o_m_reg, 32'hAD123455);

        // No advance: nothing changes
        cyc(0, 0, OP_LOAD_T, 32'h0BADF00D, 0, 0, 0, 1, 0, 0);
        check("noadv_m", bus.o_m_reg, 32'hAD123455);
        check("noadv_mb", bus.o_mb, 1);

        // Channel 1 untouched so far
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        check("ch1_m", bus.o_m_reg, 0);
        check("ch1_mb", bus.o_mb, 0);

        // Store path: ch0 STORE, ch1 LOAD_T while pending, no ack
        cyc(1, 0, OP_LOAD_T, 32'hCAFEF00D, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, OP_STORE, 0, 0, 0, 0, 0, 0, 0);
        check("st_req", bus.o_st_req, 1);
        check("st_data", bus.o_st_data, 32'hCAFEF00D);
        check("st_ch", bus.o_st_ch, 0);
        cyc(1, 1, OP_LOAD_T, 32'h01020304, 0, 0, 0, 0, 0, 0);
        check("ch1_load", bus.o_m_reg, 32'h01020304);
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        check("req_held", bus.o_st_req, 1);
        check("data_held", bus.o_st_data, 32'hCAFEF00D);
        cyc(1, 1, OP_STORE, 0, 0, 0, 0, 0, 0, 0);
        check("overrun", bus.o_overrun, 1);
        check("ovr_ch", bus.o_st_ch, 0);
        check("ovr_data", bus.o_st_data, 32'hCAFEF00D);
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 1);
        check("ovr_pulse", bus.o_overrun, 0);
        check("ack_req", bus.o_st_req, 0);
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 1);
        check("idle_ack", bus.o_st_req, 0);

        // New store from ch1, then STORE in the ack cycle is rejected
        cyc(1, 1, OP_STORE, 0, 0, 0, 0, 0, 0, 0);
        check("st_req2", bus.o_st_req, 1);
        check("st_ch2", bus.o_st_ch, 1);
        check("st_data2", bus.o_st_data, 32'h01020304);
        cyc(1, 0, OP_STORE, 0, 0, 0, 0, 0, 0, 1);
        check("ack_ovr", bus.o_overrun, 1);
        check("ack_ovr_req", bus.o_st_req, 0);

        // Reset during REQ
        cyc(1, 0, OP_STORE, 0, 0, 0, 0, 0, 0, 0);
        check("req3", bus.o_st_req, 1);
        rst = 1'b1;
        cyc(1, 0, OP_LOAD_T, 32'h77777777, 0, 1, 3, 0, 0, 0);
        rst = 1'b0;
        check("rr_m", bus.o_m_reg, 0);
        check("rr_mb", bus.o_mb, 0);
        check("rr_req", bus.o_st_req, 0);
        check("rr_data", bus.o_st_data, 0);
        check("rr_ch", bus.o_st_ch, 0);
        check("rr_ovr", bus.o_overrun, 0);
        cyc(0, 1, OP_HOLD, 0, 0, 0, 0, 0, 0, 0);
        check("rr_ch1_m", bus.o_m_reg, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
`default_nettype wire
